alu_dispatch_ctrl: RTL and testbench
====================================

Name: alu_dispatch_ctrl

Overview:
- Scheduler in front of the two-slot ALU reservation station.
- Buffers decoded ALU instructions in a small in-order FIFO and tracks which slot is free, covering the one-cycle lag before a loaded slot reports busy.
- Issues at most one instruction per cycle by pulsing en0/en1 with the operand bundle, choosing round-robin between free slots.
- Also counts dispatched instructions and structural-stall cycles.

Parameters:
ADDR_W, 32, pc width (addr_t)
OP_W, 6, op width (sinst_t)
TAG_W, 4, register tag width (regtag_t)
WORD_W, 32, data width (word_t)
RADDR_W, 5, destination register address width (regaddr_t)
DEPTH, 4, FIFO entries (power of two, >=2)

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  synchronous reset, active-low (rst==0 at posedge resets)
rdy  in  1  global enable; 0 freezes the block
flush  in  1  synchronous pipeline flush
in_valid  in  1  decoder offers an instruction
in_ready  out  1  FIFO can accept; a transfer occurs when in_valid&in_ready at posedge
in_pc  in  ADDR_W  instruction pc
in_op  in  OP_W  ALU op
in_tagx, in_tagy, in_tagw  in  TAG_W each  source/dest tags
in_datax, in_datay  in  WORD_W each  operand data
in_addrw  in  RADDR_W  destination register
slot_busy  in  2  busy of RS slot 1:0 (alu_busy1_out, alu_busy0_out)
en0, en1  out  1 each  registered one-cycle load strobe to slot 0 / slot 1
out_pc, out_op, out_tagx, out_tagy, out_tagw, out_datax, out_datay, out_addrw  out  as inputs  registered bundle, wired to both slot port groups
disp_cnt  out  32  dispatched-instruction count, wraps
stall_cnt  out  32  structural-stall cycle count, wraps

Behaviour:
- Reset (rst==0 at posedge; overrides everything):
  - FIFO empty, pointers 0, en0=en1=0, all out_* = 0, resv=2'b00.
  - last=1, so slot 0 is chosen first.
  - disp_cnt=stall_cnt=0.
  - in_ready is forced 0 combinationally while rst==0.
- FIFO:
  - in_ready = rst & rdy & !flush & (count<DEPTH); no full-bypass.
  - Pointers wrap modulo DEPTH.
  - count updates by +1 on push, -1 on pop, unchanged on simultaneous push and pop.
- Slot free: free[k] = !slot_busy[k] & !resv[k].
  - resv[k] is set at the posedge that raises en_k.
  - resv[k] clears at the first posedge where slot_busy[k]==1 is sampled.
  - Set takes priority over clear in the same edge.
- Dispatch decision (combinational, registered at posedge), when rdy==1, flush==0, FIFO non-empty and any free[k]:
  - Only one free: pick it.
  - Both free: pick !last.
  - Pop the head; drive en_k=1 and the out_* bundle from the head entry.
  - last<=k; disp_cnt++.
- Otherwise en0=en1=0 at that edge and out_* hold their value.
  - en pulses last exactly one cycle; en0 and en1 are never both 1.
- Latency: an instruction accepted into an empty FIFO at edge E with a free slot raises en at edge E+1. No same-edge bypass.
- Stall: an edge with rdy==1, flush==0, FIFO non-empty and free==2'b00 increments stall_cnt.
- rdy==0: no push, no pop, en forced 0 at that edge. FIFO, resv, last and counters hold, except resv clearing from slot_busy continues.
- flush==1 (honoured regardless of rdy):
  - FIFO emptied, en0=en1=0 at that edge, any same-cycle in_valid dropped.
  - resv, last and counters are unchanged, because loaded slots drain naturally.
- Reset mid-operation discards the FIFO contents and any pending en without side effects.

Test Plan:
- Reset: hold rst=0 for 2 cycles with in_valid=1 -> in_ready=0, en0=en1=0, counters 0; first post-reset push with both slots free -> en0=1 one cycle later, disp_cnt=1.
- Round-robin: push pc=0x100, 0x104, 0x108 back-to-back, slot_busy=0 but echoing each en one cycle later -> en0(0x100), en1(0x104), then 0x108 waits until slot 0 is free; never two dispatches to one slot before its busy is seen.
- Full FIFO: slot_busy=2'b11, push DEPTH=4 entries -> in_ready=0 after the 4th; a 5th in_valid is not accepted; stall_cnt increments every cycle; release slot_busy[1] -> en1 with the oldest pc; in_ready returns to 1.
- Wrap-around: stream 10 instructions with random slot-busy gaps -> dispatch order equals push order, disp_cnt=10, no loss or duplication.
- Flush: 3 queued entries, assert flush together with in_valid -> en stays 0, FIFO empty next cycle, next push dispatches pc of the new instruction only.
- rdy low: queue 2 entries and hold rdy=0 for 5 cycles -> no en, stall_cnt unchanged, in_ready=0; rdy=1 -> dispatch resumes in order.

Source files
------------

// File: rtl/alu_dispatch_ctrl.sv
// alu_dispatch_ctrl: in-order FIFO scheduler feeding the two-slot ALU
// reservation station. Instructions from the decoder are buffered here and
// issued one per cycle to whichever slot is free. When both slots are free,
// the slot not used last is chosen. A per-slot reservation bit covers the
// cycle between loading a slot and that slot reporting busy.
module alu_dispatch_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int OP_W    = 6,
  parameter int TAG_W   = 4,
  parameter int WORD_W  = 32,
  parameter int RADDR_W = 5,
  parameter int DEPTH   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rdy,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [ADDR_W-1:0]  in_pc,
  input  logic [OP_W-1:0]    in_op,
  input  logic [TAG_W-1:0]   in_tagx,
  input  logic [TAG_W-1:0]   in_tagy,
  input  logic [TAG_W-1:0]   in_tagw,
  input  logic [WORD_W-1:0]  in_datax,
  input  logic [WORD_W-1:0]  in_datay,
  input  logic [RADDR_W-1:0] in_addrw,
  input  logic [1:0]         slot_busy,
  output logic               en0,
  output logic               en1,
  output logic [ADDR_W-1:0]  out_pc,
  output logic [OP_W-1:0]    out_op,
  output logic [TAG_W-1:0]   out_tagx,
  output logic [TAG_W-1:0]   out_tagy,
  output logic [TAG_W-1:0]   out_tagw,
  output logic [WORD_W-1:0]  out_datax,
  output logic [WORD_W-1:0]  out_datay,
  output logic [RADDR_W-1:0] out_addrw,
  output logic [31:0]        disp_cnt,
  output logic [31:0]        stall_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = ADDR_W + OP_W + 3*TAG_W + 2*WORD_W + RADDR_W;

  logic [ENT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  logic [ENT_W-1:0] in_ent;
  logic [ENT_W-1:0] head_ent;
  logic [ENT_W-1:0] out_ent;

  logic [1:0] resv;
  logic [1:0] resv_nxt;
  logic [1:0] free;
  logic       last;
  logic       push;
  logic       pop;
  logic       stall;
  logic       sel;
  logic       active;

  assign in_ent   = {in_pc, in_op, in_tagx, in_tagy, in_tagw, in_datax, in_datay, in_addrw};
  assign head_ent = mem[rd_ptr];
  assign {out_pc, out_op, out_tagx, out_tagy, out_tagw, out_datax, out_datay, out_addrw} = out_ent;

  // Handshake, slot availability and the issue/stall decision for this edge
  always_comb begin
    in_ready = rst & rdy & ~flush & (count < CNT_W'(DEPTH));
    push     = in_valid & in_ready;
    free     = ~slot_busy & ~resv;
    active   = rdy & ~flush & (count != '0);
    pop      = active & (|free);
    stall    = active & (free == 2'b00);
    sel      = (free == 2'b11) ? ~last : free[1];
    resv_nxt = {pop & sel, pop & ~sel} | (resv & ~slot_busy);
  end

  // Entry storage; only written on an accepted push, so it needs no reset
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_ent;
    end
  end

  // FIFO pointers and occupancy; flush and reset both empty the queue
  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Registered load strobes and operand bundle; the bundle holds between issues
  always_ff @(posedge clk) begin
    if (!rst) begin
      en0     <= 1'b0;
      en1     <= 1'b0;
      out_ent <= '0;
    end else begin
      en0 <= pop & ~sel;
      en1 <= pop & sel;
      if (pop) begin
        out_ent <= head_ent;
      end
    end
  end

  // Slot reservations, round-robin history and activity counters
  always_ff @(posedge clk) begin
    if (!rst) begin
      resv      <= 2'b00;
      last      <= 1'b1;
      disp_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      resv <= resv_nxt;
      if (pop) begin
        last     <= sel;
        disp_cnt <= disp_cnt + 32'd1;
      end
      if (stall) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_alu_dispatch_ctrl.sv
// tb_alu_dispatch_ctrl: directed checks of the ALU dispatch scheduler with
// hand-computed expected values.
module tb_alu_dispatch_ctrl;

  localparam int ADDR_W  = 32;
  localparam int OP_W    = 6;
  localparam int TAG_W   = 4;
  localparam int WORD_W  = 32;
  localparam int RADDR_W = 5;
  localparam int DEPTH   = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic               rdy;
  logic               flush;
  logic               in_valid;
  logic               in_ready;
  logic [ADDR_W-1:0]  in_pc;
  logic [OP_W-1:0]    in_op;
  logic [TAG_W-1:0]   in_tagx, in_tagy, in_tagw;
  logic [WORD_W-1:0]  in_datax, in_datay;
  logic [RADDR_W-1:0] in_addrw;
  logic [1:0]         slot_busy;
  logic               en0, en1;
  logic [ADDR_W-1:0]  out_pc;
  logic [OP_W-1:0]    out_op;
  logic [TAG_W-1:0]   out_tagx, out_tagy, out_tagw;
  logic [WORD_W-1:0]  out_datax, out_datay;
  logic [RADDR_W-1:0] out_addrw;
  logic [31:0]        disp_cnt, stall_cnt;

  int errors = 0;
  int checks = 0;

  alu_dispatch_ctrl #(
    .ADDR_W(ADDR_W), .OP_W(OP_W), .TAG_W(TAG_W),
    .WORD_W(WORD_W), .RADDR_W(RADDR_W), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_op(in_op), .in_tagx(in_tagx), .in_tagy(in_tagy),
    .in_tagw(in_tagw), .in_datax(in_datax), .in_datay(in_datay), .in_addrw(in_addrw),
    .slot_busy(slot_busy), .en0(en0), .en1(en1),
    .out_pc(out_pc), .out_op(out_op), .out_tagx(out_tagx), .out_tagy(out_tagy),
    .out_tagw(out_tagw), .out_datax(out_datax), .out_datay(out_datay), .out_addrw(out_addrw),
    .disp_cnt(disp_cnt), .stall_cnt(stall_cnt)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Global watchdog so the run can never hang
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; rdy = 1'b1; flush = 1'b0; in_valid = 1'b0; slot_busy = 2'b00;
    in_pc = '0; in_op = '0; in_tagx = '0; in_tagy = '0; in_tagw = '0;
    in_datax = '0; in_datay = '0; in_addrw = '0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; rdy = 1'b1; flush = 1'b0; in_valid = 1'b1; in_pc = 32'h40; slot_busy = 2'b00;
    in_op = 6'h2a; in_tagx = 4'h3; in_tagy = 4'h5; in_tagw = 4'h9;
    in_datax = 32'hdeadbeef; in_datay = 32'h12345678; in_addrw = 5'd17;
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_in_ready: got %b expected 0", in_ready); end
      checks++; if ({en1, en0} !== 2'b00) begin errors++; $display("[TB] FAIL reset_en: got %b expected 00", {en1, en0}); end
      checks++; if (disp_cnt !== 32'd0) begin errors++; $display("[TB] FAIL reset_disp_cnt: got %0d expected 0", disp_cnt); end
      checks++; if (stall_cnt !== 32'd0) begin errors++; $display("[TB] FAIL reset_stall_cnt: got %0d expected 0", stall_cnt); end
      checks++; if (out_pc !== 32'h0) begin errors++; $display("[TB] FAIL reset_out_pc: got %h expected 0", out_pc); end
    end
    rst = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL post_reset_in_ready: got %b expected 1", in_ready); end
    tick();
    in_valid = 1'b0;
    checks++; if ({en1, en0} !== 2'b00) begin errors++; $display("[TB] FAIL no_bypass_en: got %b expected 00", {en1, en0}); end
    tick();
    checks++; if ({en1, en0} !== 2'b01) begin errors++; $display("[TB] FAIL first_dispatch_en: got %b expected 01", {en1, en0}); end
    checks++; if (out_pc !== 32'h40) begin errors++; $display("[TB] FAIL first_dispatch_pc: got %h expected 40", out_pc); end
    checks++; if (out_op !== 6'h2a) begin errors++; $display("[TB] FAIL bundle_op: got %h expected 2a", out_op); end
    checks++; if ({out_tagx, out_tagy, out_tagw} !== 12'h359) begin errors++; $display("[TB] FAIL bundle_tags: got %h expected 359", {out_tagx, out_tagy, out_tagw}); end
    checks++; if ({out_datax, out_datay} !== 64'hdeadbeef_12345678) begin errors++; $display("[TB] FAIL bundle_data: got %h expected deadbeef12345678", {out_datax, out_datay}); end
    checks++; if (out_addrw !== 5'd17) begin errors++; $display("[TB] FAIL bundle_addrw: got %0d expected 17", out_addrw); end
    checks++; if (disp_cnt !== 32'd1) begin errors++; $display("[TB] FAIL first_disp_cnt: got %0d expected 1", disp_cnt); end
    slot_busy = 2'b01;
    tick();
    checks++; if ({en1, en0} !== 2'b00) begin errors++; $display("[TB] FAIL single_pulse_en: got %b expected 00", {en1, en0}); end
  endtask

  task automatic test_round_robin();
    logic [1:0]  exp_en [3] = '{2'b01, 2'b10, 2'b01};
    logic [31:0] exp_pc [3] = '{32'h100, 32'h104, 32'h108};
    do_reset();
    for (int c = 0; c < 5; c++) begin
      in_valid = (c < 3);
      in_pc = 32'h100 + 32'(4 * c);
      tick();
      slot_busy = {en1, en0};
      if (c >= 1 && c <= 3) begin
        checks++; if ({en1, en0} !== exp_en[c-1]) begin errors++; $display("[TB] FAIL rr_en_%0d: got %b expected %b", c, {en1, en0}, exp_en[c-1]); end
        checks++; if (out_pc !== exp_pc[c-1]) begin errors++; $display("[TB] FAIL rr_pc_%0d: got %h expected %h", c, out_pc, exp_pc[c-1]); end
      end
    end
    in_valid = 1'b0;
    checks++; if ({en1, en0} !== 2'b00) begin errors++; $display("[TB] FAIL rr_idle_en: got %b expected 00", {en1, en0}); end
    checks++; if (out_pc !== 32'h108) begin errors++; $display("[TB] FAIL rr_bundle_hold: got %h expected 108", out_pc); end
    checks++; if (disp_cnt !== 32'd3) begin errors++; $display("[TB] FAIL rr_disp_cnt: got %0d expected 3", disp_cnt); end
  endtask

  task automatic test_full_fifo();
    logic [31:0] exp_pc [3] = '{32'h204, 32'h208, 32'h20c};
    int j = 0;
    do_reset();
    slot_busy = 2'b11;
    for (int c = 0; c < 4; c++) begin
      in_valid = 1'b1;
      in_pc = 32'h200 + 32'(4 * c);
      tick();
    end
    in_pc = 32'h210;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL full_in_ready: got %b expected 0", in_ready); end
    checks++; if (stall_cnt !== 32'd3) begin errors++; $display("[TB] FAIL full_stall_3: got %0d expected 3", stall_cnt); end
    tick();
    checks++; if (stall_cnt !== 32'd4) begin errors++; $display("[TB] FAIL full_stall_4: got %0d expected 4", stall_cnt); end
    checks++; if ({en1, en0} !== 2'b00) begin errors++; $display("[TB] FAIL full_no_en: got %b expected 00", {en1, en0}); end
    in_valid = 1'b0;
    slot_busy = 2'b01;
    tick();
    checks++; if ({en1, en0} !== 2'b10) begin errors++; $display("[TB] FAIL full_release_en: got %b expected 10", {en1, en0}); end
    checks++; if (out_pc !== 32'h200) begin errors++; $display("[TB] FAIL full_release_pc: got %h expected 200", out_pc); end
    checks++; if (stall_cnt !== 32'd4) begin errors++; $display("[TB] FAIL full_stall_hold: got %0d expected 4", stall_cnt); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL full_in_ready_back: got %b expected 1", in_ready); end
    for (int c = 0; c < 16; c++) begin
      slot_busy = {en1, en0};
      tick();
      if (en0 | en1) begin
        checks++;
        if (j >= 3) begin errors++; $display("[TB] FAIL full_extra_dispatch: got pc %h expected none", out_pc); end
        else if (out_pc !== exp_pc[j]) begin errors++; $display("[TB] FAIL full_drain_pc_%0d: got %h expected %h", j, out_pc, exp_pc[j]); end
        j++;
      end
    end
    checks++; if (disp_cnt !== 32'd4) begin errors++; $display("[TB] FAIL full_disp_cnt: got %0d expected 4", disp_cnt); end
  endtask

  task automatic test_wrap_around();
    logic [31:0] exp_q [$];
    logic        acc;
    int i = 0;
    int cyc = 0;
    do_reset();
    while ((i < 10 || exp_q.size() > 0) && cyc < 300) begin
      in_valid = (i < 10);
      in_pc = 32'h300 + 32'(4 * i);
      #1;
      acc = in_valid & in_ready;
      tick();
      cyc++;
      if (acc) begin exp_q.push_back(in_pc); i++; end
      checks++; if ((en0 & en1) !== 1'b0) begin errors++; $display("[TB] FAIL wrap_en_exclusive: got %b expected not 11", {en1, en0}); end
      if (en0 | en1) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("[TB] FAIL wrap_spurious: got pc %h expected no dispatch", out_pc); end
        else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          if (out_pc !== e) begin errors++; $display("[TB] FAIL wrap_order: got %h expected %h", out_pc, e); end
        end
      end
      slot_busy = {en1, en0} | 2'($urandom_range(0, 3));
    end
    in_valid = 1'b0;
    slot_busy = 2'b00;
    checks++; if (cyc >= 300) begin errors++; $display("[TB] FAIL wrap_timeout: got %0d cycles expected under 300", cyc); end
    checks++; if (disp_cnt !== 32'd10) begin errors++; $display("[TB] FAIL wrap_disp_cnt: got %0d expected 10", disp_cnt); end
  endtask

  task automatic test_flush();
    do_reset();
    slot_busy = 2'b11;
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1;
      in_pc = 32'h400 + 32'(4 * c);
      tick();
    end
    flush = 1'b1; in_valid = 1'b1; in_pc = 32'h4f0; slot_busy = 2'b00;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL flush_in_ready: got %b expected 0", in_ready); end
    tick();
    checks++; if ({en1, en0} !== 2'b00) begin errors++; $display("[TB] FAIL flush_en: got %b expected 00", {en1, en0}); end
    checks++; if (stall_cnt !== 32'd2) begin errors++; $display("[TB] FAIL flush_stall_cnt: got %0d expected 2", stall_cnt); end
    flush = 1'b0; in_valid = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL flush_ready_after: got %b expected 1", in_ready); end
    tick();
    checks++; if ({en1, en0} !== 2'b00) begin errors++; $display("[TB] FAIL flush_empty_en: got %b expected 00", {en1, en0}); end
    in_valid = 1'b1; in_pc = 32'h500;
    tick();
    in_valid = 1'b0;
    tick();
    checks++; if ({en1, en0} !== 2'b01) begin errors++; $display("[TB] FAIL flush_new_en: got %b expected 01", {en1, en0}); end
    checks++; if (out_pc !== 32'h500) begin errors++; $display("[TB] FAIL flush_new_pc: got %h expected 500", out_pc); end
    slot_busy = 2'b01;
    tick();
    slot_busy = 2'b00;
    tick();
    checks++; if ({en1, en0} !== 2'b00) begin errors++; $display("[TB] FAIL flush_no_stale_en: got %b expected 00", {en1, en0}); end
    checks++; if (disp_cnt !== 32'd1) begin errors++; $display("[TB] FAIL flush_disp_cnt: got %0d expected 1", disp_cnt); end
  endtask

  task automatic test_rdy_low();
    do_reset();
    slot_busy = 2'b11;
    for (int c = 0; c < 2; c++) begin
      in_valid = 1'b1;
      in_pc = 32'h600 + 32'(4 * c);
      tick();
    end
    rdy = 1'b0; slot_busy = 2'b00; in_valid = 1'b1; in_pc = 32'h6f0;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL rdy_in_ready_%0d: got %b expected 0", c, in_ready); end
      tick();
      checks++; if ({en1, en0} !== 2'b00) begin errors++; $display("[TB] FAIL rdy_en_%0d: got %b expected 00", c, {en1, en0}); end
      checks++; if (stall_cnt !== 32'd1) begin errors++; $display("[TB] FAIL rdy_stall_%0d: got %0d expected 1", c, stall_cnt); end
    end
    rdy = 1'b1; in_valid = 1'b0;
    tick();
    checks++; if ({en1, en0} !== 2'b01) begin errors++; $display("[TB] FAIL rdy_resume_en0: got %b expected 01", {en1, en0}); end
    checks++; if (out_pc !== 32'h600) begin errors++; $display("[TB] FAIL rdy_resume_pc0: got %h expected 600", out_pc); end
    slot_busy = {en1, en0};
    tick();
    checks++; if ({en1, en0} !== 2'b10) begin errors++; $display("[TB] FAIL rdy_resume_en1: got %b expected 10", {en1, en0}); end
    checks++; if (out_pc !== 32'h604) begin errors++; $display("[TB] FAIL rdy_resume_pc1: got %h expected 604", out_pc); end
    slot_busy = {en1, en0};
    tick();
    slot_busy = 2'b00;
    tick();
    checks++; if ({en1, en0} !== 2'b00) begin errors++; $display("[TB] FAIL rdy_no_extra: got %b expected 00", {en1, en0}); end
    checks++; if (disp_cnt !== 32'd2) begin errors++; $display("[TB] FAIL rdy_disp_cnt: got %0d expected 2", disp_cnt); end
  endtask

  // Run every scenario in sequence, then report
  initial begin
    test_reset();
    test_round_robin();
    test_full_fifo();
    test_wrap_around();
    test_flush();
    test_rdy_low();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
